pipe_stall_ctrl: RTL and testbench
==================================

Name: pipe_stall_ctrl

Overview:
- Pipeline sequencing controller for the 5-stage MIPS-style datapath.
- Sits beside the instruction decoder/forwarding logic and owns every pipeline-register write enable and bubble-insert signal.
- Resolves load-use hazards, which forwarding cannot cover, by a one-cycle stall plus bubble.
- Freezes the whole pipe while a multi-cycle data memory access is outstanding, with a timeout that escalates to a sticky bus error.

Parameters:
- REG_W, 5, register-number width.
- TIMEOUT, 16, maximum MEM_WAIT cycles before error (legal range 2..255).
- CNT_W, 8, width of the wait counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- id_rs  in  REG_W  rs of the instruction in ID.
- id_rt  in  REG_W  rt of the instruction in ID.
- id_uses_rt  in  1  ID instruction reads rt (R-type = 1, lw = 0).
- ex_destReg  in  REG_W  destination register of the instruction in EX.
- ex_wreg  in  1  EX instruction writes the register file.
- ex_m2reg  in  1  EX instruction is a load.
- dmem_req  in  1  MEM stage access pending; held high while frozen.
- dmem_ready  in  1  data memory completes the access this cycle.
- pc_we  out  1  PC write enable.
- ifid_we  out  1  IF/ID register write enable.
- idex_bubble  out  1  load zeros/NOP into ID/EX this cycle.
- pipe_we  out  1  write enable for ID/EX, EX/MEM, MEM/WB.
- memwb_bubble  out  1  load a NOP into MEM/WB.
- bus_err  out  1  sticky timeout error.
- lu_stalls  out  16  load-use stall count (see Optional Feature).
- mem_stalls  out  16  memory wait-cycle count (see Optional Feature).

Behaviour:
- Clock and reset: clk is the single clock. rst_n is asynchronous and active-low. Clock and reset ports are named clk and rst_n.
- Reset values: state=RUN, wait_cnt=0, bus_err=0, stat counters=0.
- Outputs while rst_n=0: pc_we=0, ifid_we=0, pipe_we=0, idex_bubble=0, memwb_bubble=0.
- Hazard definition: lu_haz = ex_wreg & ex_m2reg & (ex_destReg!=0) & ((ex_destReg==id_rs) | (id_uses_rt & ex_destReg==id_rt)).
- Output timing: all enables and bubbles are combinational from the current state and inputs (same-cycle effect). State, wait_cnt and bus_err are registered.
- RUN, no memory stall (dmem_req=0, or dmem_req=1 with dmem_ready=1 for a zero-wait access):
  - pipe_we=1.
  - If lu_haz: pc_we=0, ifid_we=0, idex_bubble=1. Exactly one stall cycle results, because the load leaves EX the next cycle.
  - Else: pc_we=1, ifid_we=1, idex_bubble=0.
  - Next state: RUN.
- RUN with dmem_req=1 and dmem_ready=0:
  - pc_we=0, ifid_we=0, pipe_we=0, memwb_bubble=1, idex_bubble=0.
  - Next state MEM_WAIT; wait_cnt<=1.
- MEM_WAIT with dmem_ready=0:
  - Same freeze outputs as above.
  - wait_cnt<=wait_cnt+1.
  - If wait_cnt==TIMEOUT-1: next state ERR, bus_err<=1.
- MEM_WAIT with dmem_ready=1:
  - Release that cycle: pipe_we=1, memwb_bubble=0, load-use rule applied as in RUN.
  - Next state RUN; wait_cnt<=0.
  - dmem_ready arriving on the timeout cycle wins: release, no error.
- ERR: all enables 0, memwb_bubble=1, bus_err=1. Exits only by reset.
- Priority: memory freeze over load-use. During a freeze idex_bubble=0, so the held ID instruction is re-evaluated after release.
- dmem_ready while dmem_req=0: ignored.
- Reset asserted mid-wait: immediate return to RUN with counters cleared; the pending access is abandoned.

Optional Feature:
- Macro: PIPE_STALL_STATS_EN.
- Defined:
  - lu_stalls increments on each RUN/MEM_WAIT-release cycle with lu_haz and no freeze.
  - mem_stalls increments on each freeze cycle, excluding ERR.
  - Both are 16-bit, saturating at 16'hFFFF.
  - Both are cleared by reset.
- Undefined: no counter logic; both ports tie to 16'h0000.

Test Plan:
- Load-use: ex lw dest=5 (wreg=1, m2reg=1), id add rs=5 rt=7 -> one cycle of pc_we=0, ifid_we=0, idex_bubble=1; next cycle all enables 1; lu_stalls=1.
- rt-only and $0 cases:
  - ex lw dest=7, id lw rt=7 with id_uses_rt=0 -> no stall.
  - ex lw dest=0, id rs=0 -> no stall.
- Memory wait: dmem_req=1, dmem_ready low for 3 cycles then high -> 3 freeze cycles (pipe_we=0, memwb_bubble=1), release on the 4th; mem_stalls=3; state back to RUN.
- Simultaneous: lu_haz=1 during a 2-cycle memory wait -> idex_bubble stays 0 while frozen; on the release cycle pc_we=0 and idex_bubble=1.
- Timeout: TIMEOUT=4, dmem_ready held 0 -> bus_err=1 after the 4th freeze cycle; all enables stay 0; rst_n pulse low clears bus_err and returns to RUN.
- Async reset: drop rst_n mid-MEM_WAIT, between clock edges -> outputs go to reset values immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/pipe_stall_ctrl.sv
// pipe_stall_ctrl: pipeline write-enable/bubble sequencer for load-use stalls and data-memory freezes (optional stats via PIPE_STALL_STATS_EN)
module pipe_stall_ctrl #(
  parameter int REG_W   = 5,
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_uses_rt,
  input  logic [REG_W-1:0] ex_destReg,
  input  logic             ex_wreg,
  input  logic             ex_m2reg,
  input  logic             dmem_req,
  input  logic             dmem_ready,
  output logic             pc_we,
  output logic             ifid_we,
  output logic             idex_bubble,
  output logic             pipe_we,
  output logic             memwb_bubble,
  output logic             bus_err,
  output logic [15:0]      lu_stalls,
  output logic [15:0]      mem_stalls
);
  typedef enum logic [1:0] {RUN, MEM_WAIT, ERR} state_t;
  state_t state_q, state_d;
  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic bus_err_q, bus_err_d;
  logic lu_haz, freeze, err, go;
  assign lu_haz = ex_wreg & ex_m2reg & (ex_destReg != '0) &
                  ((ex_destReg == id_rs) | (id_uses_rt & (ex_destReg == id_rt)));
  // Outputs are gated by rst_n so the pipe is held the instant reset asserts
  always_comb begin
    freeze       = rst_n & ~dmem_ready & ((state_q == RUN & dmem_req) | state_q == MEM_WAIT);
    err          = rst_n & (state_q == ERR);
    go           = rst_n & ~freeze & ~err;
    pipe_we      = go;
    pc_we        = go & ~lu_haz;
    ifid_we      = go & ~lu_haz;
    idex_bubble  = go & lu_haz;
    memwb_bubble = freeze | err;
    bus_err      = bus_err_q;
  end
  // Next state: a timeout escalates to ERR unless dmem_ready arrives on that same cycle
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    bus_err_d  = bus_err_q;
    if (state_q == RUN && dmem_req && !dmem_ready) begin
      state_d    = MEM_WAIT;
      wait_cnt_d = CNT_W'(1);
    end else if (state_q == MEM_WAIT) begin
      if (dmem_ready) begin
        state_d    = RUN;
        wait_cnt_d = '0;
      end else begin
        wait_cnt_d = wait_cnt_q + CNT_W'(1);
        if (wait_cnt_q == CNT_W'(TIMEOUT - 1)) begin
          state_d   = ERR;
          bus_err_d = 1'b1;
        end
      end
    end
  end
  // State, wait counter and sticky error register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= RUN;
      wait_cnt_q <= '0;
      bus_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      bus_err_q  <= bus_err_d;
    end
  end
`ifdef PIPE_STALL_STATS_EN
  logic [15:0] lu_q, ms_q;
  // Saturating stall statistics; ERR cycles are not counted as freezes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lu_q <= '0;
      ms_q <= '0;
    end else begin
      if (go && lu_haz && lu_q != 16'hFFFF) lu_q <= lu_q + 16'd1;
      if (freeze && ms_q != 16'hFFFF) ms_q <= ms_q + 16'd1;
    end
  end
  assign lu_stalls  = lu_q;
  assign mem_stalls = ms_q;
`else
  assign lu_stalls  = 16'h0000;
  assign mem_stalls = 16'h0000;
`endif
endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// tb_pipe_stall_ctrl: scoreboard bench for pipe_stall_ctrl with directed hand-computed vectors
module tb_pipe_stall_ctrl;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [4:0] id_rs = '0, id_rt = '0, ex_destReg = '0;
  logic id_uses_rt = 1'b0, ex_wreg = 1'b0, ex_m2reg = 1'b0, dmem_req = 1'b0, dmem_ready = 1'b0;
  logic pc_we, ifid_we, idex_bubble, pipe_we, memwb_bubble, bus_err;
  logic [15:0] lu_stalls, mem_stalls;
  int n_chk = 0, n_fail = 0;
`ifdef PIPE_STALL_STATS_EN
  localparam bit ST = 1'b1;
`else
  localparam bit ST = 1'b0;
`endif
  typedef struct {
    string       nm;
    logic [5:0]  o;
    logic [15:0] lu;
    logic [15:0] ms;
  } exp_t;
  exp_t q[$];
  pipe_stall_ctrl #(.REG_W(5), .TIMEOUT(4), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .ex_destReg(ex_destReg), .ex_wreg(ex_wreg), .ex_m2reg(ex_m2reg),
    .dmem_req(dmem_req), .dmem_ready(dmem_ready), .pc_we(pc_we), .ifid_we(ifid_we),
    .idex_bubble(idex_bubble), .pipe_we(pipe_we), .memwb_bubble(memwb_bubble),
    .bus_err(bus_err), .lu_stalls(lu_stalls), .mem_stalls(mem_stalls)
  );
  always #5 clk = ~clk;
  // Monitor: outputs are combinational, so every cycle presents a result checked mid-cycle
  always @(negedge clk) begin
    if (q.size() != 0) begin
      exp_t e;
      logic [5:0] act;
      logic [15:0] elu, ems;
      e   = q.pop_front();
      act = {pc_we, ifid_we, idex_bubble, pipe_we, memwb_bubble, bus_err};
      elu = ST ? e.lu : 16'h0;
      ems = ST ? e.ms : 16'h0;
      n_chk++;
      if (act !== e.o) begin
        n_fail++;
        $display("FAIL %s outs {pc,ifid,idb,pwe,mwb,err} got %b want %b", e.nm, act, e.o);
      end
      n_chk++;
      if (lu_stalls !== elu || mem_stalls !== ems) begin
        n_fail++;
        $display("FAIL %s stats got lu=%0d ms=%0d want lu=%0d ms=%0d", e.nm, lu_stalls, mem_stalls, elu, ems);
      end
    end
  end
  task automatic step(input string nm, input logic r, input logic [4:0] rs, input logic [4:0] rt,
                      input logic ut, input logic [4:0] ed, input logic ld, input logic req,
                      input logic rdy, input logic [5:0] o, input logic [15:0] lu, input logic [15:0] ms);
    exp_t e;
    @(posedge clk);
    #1;
    rst_n = r; id_rs = rs; id_rt = rt; id_uses_rt = ut; ex_destReg = ed;
    ex_wreg = ld; ex_m2reg = ld; dmem_req = req; dmem_ready = rdy;
    e.nm = nm; e.o = o; e.lu = lu; e.ms = ms;
    q.push_back(e);
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end
  initial begin
    //    name         rst rs  rt  ut  ed  ld req rdy  outs         lu ms
    step("reset",      0,  0,  0,  0,  0,  0, 0,  0,  6'b000000,  0, 0);
    step("idle",       1,  0,  0,  0,  0,  0, 0,  0,  6'b110100,  0, 0);
    step("lu_rs",      1,  5,  7,  1,  5,  1, 0,  0,  6'b001100,  0, 0);
    step("lu_after",   1,  5,  7,  1,  0,  0, 0,  0,  6'b110100,  1, 0);
    step("rt_unused",  1,  3,  7,  0,  7,  1, 0,  0,  6'b110100,  1, 0);
    step("dest_zero",  1,  0,  0,  1,  0,  1, 0,  0,  6'b110100,  1, 0);
    step("lu_rt",      1,  3,  7,  1,  7,  1, 0,  0,  6'b001100,  1, 0);
    step("lu_rt_aft",  1,  3,  7,  1,  0,  0, 0,  0,  6'b110100,  2, 0);
    step("mw_f1",      1,  0,  0,  0,  0,  0, 1,  0,  6'b000010,  2, 0);
    step("mw_f2",      1,  0,  0,  0,  0,  0, 1,  0,  6'b000010,  2, 1);
    step("mw_f3",      1,  0,  0,  0,  0,  0, 1,  0,  6'b000010,  2, 2);
    step("mw_rel",     1,  0,  0,  0,  0,  0, 1,  1,  6'b110100,  2, 3);
    step("mw_run",     1,  0,  0,  0,  0,  0, 0,  0,  6'b110100,  2, 3);
    step("zero_wait",  1,  0,  0,  0,  0,  0, 1,  1,  6'b110100,  2, 3);
    step("rdy_noreq",  1,  0,  0,  0,  0,  0, 0,  1,  6'b110100,  2, 3);
    step("sim_f1",     1,  5,  7,  1,  5,  1, 1,  0,  6'b000010,  2, 3);
    step("sim_f2",     1,  5,  7,  1,  5,  1, 1,  0,  6'b000010,  2, 4);
    step("sim_rel",    1,  5,  7,  1,  5,  1, 1,  1,  6'b001100,  2, 5);
    step("sim_after",  1,  5,  7,  1,  0,  0, 0,  0,  6'b110100,  3, 5);
    step("to_f1",      1,  0,  0,  0,  0,  0, 1,  0,  6'b000010,  3, 5);
    step("to_f2",      1,  0,  0,  0,  0,  0, 1,  0,  6'b000010,  3, 6);
    step("to_f3",      1,  0,  0,  0,  0,  0, 1,  0,  6'b000010,  3, 7);
    step("to_f4",      1,  0,  0,  0,  0,  0, 1,  0,  6'b000010,  3, 8);
    step("err",        1,  0,  0,  0,  0,  0, 1,  0,  6'b000011,  3, 9);
    step("err_sticky", 1,  0,  0,  0,  0,  0, 1,  1,  6'b000011,  3, 9);
    step("err_reset",  0,  0,  0,  0,  0,  0, 1,  1,  6'b000000,  0, 0);
    step("err_clear",  1,  0,  0,  0,  0,  0, 0,  0,  6'b110100,  0, 0);
    step("edge_f1",    1,  0,  0,  0,  0,  0, 1,  0,  6'b000010,  0, 0);
    step("edge_f2",    1,  0,  0,  0,  0,  0, 1,  0,  6'b000010,  0, 1);
    step("edge_f3",    1,  0,  0,  0,  0,  0, 1,  0,  6'b000010,  0, 2);
    step("edge_win",   1,  0,  0,  0,  0,  0, 1,  1,  6'b110100,  0, 3);
    step("edge_run",   1,  0,  0,  0,  0,  0, 0,  0,  6'b110100,  0, 3);
    step("ar_f1",      1,  0,  0,  0,  0,  0, 1,  0,  6'b000010,  0, 3);
    step("ar_f2",      1,  0,  0,  0,  0,  0, 1,  0,  6'b000010,  0, 4);
    step("ar_async",   0,  0,  0,  0,  0,  0, 1,  0,  6'b000000,  0, 0);
    step("ar_run",     1,  0,  0,  0,  0,  0, 0,  0,  6'b110100,  0, 0);
    @(negedge clk);
    #1;
    n_chk++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain got %0d pending want 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
